regwrite_arbiter: RTL and testbench
===================================

# regwrite_arbiter

Shares the register file's single write port between the pipeline writeback stage and an auxiliary multi-cycle producer, such as a load-return path or a multiply/divide unit. Writeback requests take priority. Auxiliary writes wait in a small FIFO. A starvation counter forces one auxiliary write through by stalling the pipeline for one cycle. The block drives the registered write port, the ENDWRITE/ENDREG commit strobe used for forwarding, and a per-register pending vector used by hazard detection.

## Interface
- FIFO_DEPTH, 2, auxiliary queue depth; power of two, ≥2
- STARVE_LIMIT, 4, consecutive blocked cycles before a forced auxiliary grant; ≥1
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- WB_ON  in  1  writeback write request
- WB_ADDR  in  4  writeback destination register
- WB_DATA  in  16  writeback data
- AUX_VALID  in  1  auxiliary write offered
- AUX_ADDR  in  4  auxiliary destination register
- AUX_DATA  in  16  auxiliary data
- AUX_READY  out  1  queue can accept; equals !full, combinational from stored count
- RF_WE  out  1  register-file write enable, registered
- RF_WADDR  out  4  register-file write address, registered
- RF_WDATA  out  16  register-file write data, registered
- ENDWRITE  out  1  commit strobe; identical to RF_WE
- ENDREG  out  4  committed register; identical to RF_WADDR
- PIPE_STALL  out  1  registered; high only in state FORCE
- PENDING  out  16  bit i high while any stored queue entry targets register i

## Operation
- Reset state:
  - queue empty; state NORMAL; starvation counter 0.
  - RF_WE, RF_WADDR, RF_WDATA, ENDWRITE, ENDREG, PIPE_STALL and PENDING all 0.
  - AUX_READY 1.
  - Reset asserted mid-operation discards queued entries and any in-flight grant.
- Enqueue: at an edge where AUX_VALID & AUX_READY, append {AUX_ADDR, AUX_DATA}.
  - When full, AUX_READY is 0 even if a pop occurs in the same cycle.
  - The producer holds its offer while AUX_READY is 0.
- Grant, state NORMAL:
  - If WB_ON: grant writeback.
  - Else if queue non-empty: grant the queue head and pop it.
  - Else: no grant.
- Grant, state FORCE:
  - Grant the queue head and pop it, regardless of WB_ON.
  - The writeback stage, seeing PIPE_STALL, must present the same request again in the next cycle. The block does not store it.
- Commit: the granted source's address and data are registered onto RF_*/ENDREG with RF_WE = ENDWRITE = 1. With no grant, RF_WE = ENDWRITE = 0 and RF_WADDR/RF_WDATA/ENDREG hold their previous values.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - Increments at each edge in NORMAL where the queue is non-empty and the head is not popped.
  - Clears to 0 at any pop or when the queue is empty.
- State transitions:
  - NORMAL → FORCE at the edge where the counter would reach STARVE_LIMIT; the counter is cleared.
  - FORCE → NORMAL after exactly one cycle.
  - PIPE_STALL = (state == FORCE).
- PENDING is an OR over valid stored entries, combinational from registered queue contents. An entry stops contributing at its pop edge, which is the same edge that raises its RF_WE.
- Ordering: writes commit in grant order. There is no address-conflict reordering. Register 0 writes pass through unchanged; the register file ignores them.

## Timing
- Writeback: WB_ON sampled high at edge n (no FORCE) → RF_WE = 1 during cycle n+1.
- Auxiliary: accepted at edge n → visible in queue and PENDING in cycle n+1 → earliest RF_WE in cycle n+2.
- Forced grant: entry at head from cycle n with WB_ON continuously high (STARVE_LIMIT = 4):
  - blocked at edges n..n+3;
  - PIPE_STALL = 1 in cycle n+4;
  - pop at end of n+4;
  - auxiliary RF_WE in cycle n+5;
  - PIPE_STALL = 0 in cycle n+5.
- Maximum committed writes: one per cycle.
- Back-to-back FORCE requires a fresh STARVE_LIMIT count.

## Test plan
- Reset: hold RST 2 cycles with AUX_VALID = 1. Required: all outputs 0, AUX_READY = 1, nothing enqueued.
- Writeback only: WB_ON = 1, WB_ADDR = 3, WB_DATA = 16'h1234. Required next cycle: RF_WE = 1, RF_WADDR = 3, RF_WDATA = 16'h1234, ENDWRITE = 1, ENDREG = 3.
- Aux when idle: AUX_VALID pulse with addr 5, data 16'hBEEF, WB_ON = 0. Required:
  - PENDING = 16'h0020 for one cycle;
  - RF_WE with addr 5 and data 16'hBEEF two cycles after acceptance;
  - PENDING = 0 in that same cycle.
- Starvation: WB_ON held high, one aux entry queued (addr 7), STARVE_LIMIT = 4. Required:
  - PIPE_STALL high exactly one cycle, four cycles after the entry appears;
  - auxiliary commit to register 7 in the following cycle;
  - writeback commits resume afterwards.
- Full queue: offer 3 aux entries with WB_ON = 1 (FIFO_DEPTH = 2). Required: AUX_READY drops after the 2nd acceptance, and the 3rd is accepted only after a pop.
- Reset mid-operation: 2 entries queued, assert RST one cycle. Required: PENDING = 0, queue empty, no auxiliary RF_WE afterwards.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// Shares the register-file write port: writeback first, aux writes queued, starvation forces one aux grant.
// One-cycle registered commit; AUX_READY drops when the queue is full, PIPE_STALL holds writeback for a forced grant.
module regwrite_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WB_ON,
  input  logic [3:0]  WB_ADDR,
  input  logic [15:0] WB_DATA,
  input  logic        AUX_VALID,
  input  logic [3:0]  AUX_ADDR,
  input  logic [15:0] AUX_DATA,
  output logic        AUX_READY,
  output logic        RF_WE,
  output logic [3:0]  RF_WADDR,
  output logic [15:0] RF_WDATA,
  output logic        ENDWRITE,
  output logic [3:0]  ENDREG,
  output logic        PIPE_STALL,
  output logic [15:0] PENDING
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t                       state_q, state_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic [SW-1:0]                starve_q, starve_d;
  logic [FIFO_DEPTH-1:0][19:0]  mem_q, mem_d;
  logic                         rf_we_q, rf_we_d;
  logic [3:0]                   rf_waddr_q, rf_waddr_d;
  logic [15:0]                  rf_wdata_q, rf_wdata_d;
  logic                         push, pop, empty;
  logic [15:0]                  pending;
  logic [PW-1:0]                slot_off;

  always_comb begin
    empty     = (count_q == '0);
    AUX_READY = (count_q != DEPTH_C);
    push      = AUX_VALID && (count_q != DEPTH_C);
    pop       = !empty && ((state_q == FORCE) || !WB_ON);

    // Counter only advances while the head sits blocked in NORMAL
    state_d  = NORMAL;
    starve_d = '0;
    if ((state_q == NORMAL) && !empty && !pop) begin
      if (starve_q + SW'(1) == LIMIT_C) state_d = FORCE;
      else                              starve_d = starve_q + SW'(1);
    end

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop) begin
      rf_we_d                  = 1'b1;
      {rf_waddr_d, rf_wdata_d} = mem_q[rd_ptr_q];
    end else if ((state_q == NORMAL) && WB_ON) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = WB_ADDR;
      rf_wdata_d = WB_DATA;
    end

    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = {AUX_ADDR, AUX_DATA};

    pending  = '0;
    slot_off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q) pending[mem_q[i][19:16]] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= NORMAL;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      mem_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      mem_q      <= mem_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign RF_WE      = rf_we_q;
  assign RF_WADDR   = rf_waddr_q;
  assign RF_WDATA   = rf_wdata_q;
  assign ENDWRITE   = rf_we_q;
  assign ENDREG     = rf_waddr_q;
  assign PIPE_STALL = (state_q == FORCE);
  assign PENDING    = pending;
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed steps plus random traffic against a queue-based reference model.
module tb_regwrite_arbiter;
  localparam int D = 2;
  localparam int L = 4;

  logic        CLK = 1'b0;
  logic        RST, WB_ON, AUX_VALID;
  logic [3:0]  WB_ADDR, AUX_ADDR;
  logic [15:0] WB_DATA, AUX_DATA;
  logic        AUX_READY, RF_WE, ENDWRITE, PIPE_STALL;
  logic [3:0]  RF_WADDR, ENDREG;
  logic [15:0] RF_WDATA, PENDING;

  regwrite_arbiter #(.FIFO_DEPTH(D), .STARVE_LIMIT(L)) dut (
    .CLK(CLK), .RST(RST), .WB_ON(WB_ON), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .AUX_VALID(AUX_VALID), .AUX_ADDR(AUX_ADDR), .AUX_DATA(AUX_DATA),
    .AUX_READY(AUX_READY), .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .ENDWRITE(ENDWRITE), .ENDREG(ENDREG), .PIPE_STALL(PIPE_STALL), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of {addr,data}, blocked-cycle tally, one-shot stall flag
  logic [19:0] q[$];
  int          m_blk   = 0;
  bit          m_force = 1'b0;
  bit          m_accept = 1'b0;
  logic        e_we    = 1'b0;
  logic [3:0]  e_addr  = '0;
  logic [15:0] e_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_pending();
    logic [15:0] p = '0;
    foreach (q[i]) p[q[i][19:16]] = 1'b1;
    return p;
  endfunction

  task automatic model_edge();
    int  pre;
    bit  pop, gwb, nf;
    m_accept = 1'b0;
    if (RST) begin
      q.delete();
      m_blk = 0; m_force = 1'b0;
      e_we = 1'b0; e_addr = '0; e_data = '0;
      return;
    end
    pre = q.size();
    m_accept = AUX_VALID && (pre < D);
    pop = 1'b0; gwb = 1'b0; nf = 1'b0;
    if (m_force)      pop = (pre > 0);
    else if (WB_ON)   gwb = 1'b1;
    else if (pre > 0) pop = 1'b1;
    if (!m_force && pre > 0 && !pop) begin
      m_blk++;
      if (m_blk == L) begin nf = 1'b1; m_blk = 0; end
    end else begin
      m_blk = 0;
    end
    if (gwb) begin
      e_we = 1'b1; e_addr = WB_ADDR; e_data = WB_DATA;
    end else if (pop) begin
      e_we = 1'b1; {e_addr, e_data} = q[0];
    end else begin
      e_we = 1'b0;
    end
    if (pop) void'(q.pop_front());
    if (m_accept) q.push_back({AUX_ADDR, AUX_DATA});
    m_force = nf;
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    check("rf_we",      RF_WE,      e_we);
    check("endwrite",   ENDWRITE,   e_we);
    check("rf_waddr",   RF_WADDR,   e_addr);
    check("endreg",     ENDREG,     e_addr);
    check("rf_wdata",   RF_WDATA,   e_data);
    check("pipe_stall", PIPE_STALL, m_force);
    check("pending",    PENDING,    exp_pending());
    check("aux_ready",  AUX_READY,  q.size() < D);
  endtask

  initial begin
    int waits;
    RST = 1'b1; WB_ON = 1'b0; WB_ADDR = '0; WB_DATA = '0;
    AUX_VALID = 1'b1; AUX_ADDR = 4'd9; AUX_DATA = 16'h5555;

    // Reset held two cycles with an aux offer present
    cycle(); cycle();
    check("rst_rf_we", RF_WE, 1'b0);
    check("rst_stall", PIPE_STALL, 1'b0);
    check("rst_ready", AUX_READY, 1'b1);
    RST = 1'b0; AUX_VALID = 1'b0;
    cycle();
    check("rst_nothing_queued", PENDING, 16'h0000);

    // Writeback only
    WB_ON = 1'b1; WB_ADDR = 4'd3; WB_DATA = 16'h1234;
    cycle();
    check("wb_we",   RF_WE,    1'b1);
    check("wb_addr", RF_WADDR, 4'd3);
    check("wb_data", RF_WDATA, 16'h1234);
    check("wb_endreg", ENDREG, 4'd3);
    WB_ON = 1'b0;

    // Aux when idle
    AUX_VALID = 1'b1; AUX_ADDR = 4'd5; AUX_DATA = 16'hBEEF;
    cycle();
    AUX_VALID = 1'b0;
    check("aux_pending", PENDING, 16'h0020);
    cycle();
    check("aux_we",   RF_WE,    1'b1);
    check("aux_addr", RF_WADDR, 4'd5);
    check("aux_data", RF_WDATA, 16'hBEEF);
    check("aux_pending_clear", PENDING, 16'h0000);

    // Starvation with writeback held high
    WB_ON = 1'b1; WB_ADDR = 4'd2; WB_DATA = 16'h1111;
    AUX_VALID = 1'b1; AUX_ADDR = 4'd7; AUX_DATA = 16'h7777;
    cycle();
    AUX_VALID = 1'b0;
    check("starve_pending", PENDING, 16'h0080);
    check("starve_stall0", PIPE_STALL, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("starve_no_stall", PIPE_STALL, 1'b0);
    end
    cycle();
    check("starve_stall", PIPE_STALL, 1'b1);
    cycle();
    check("starve_stall_end", PIPE_STALL, 1'b0);
    check("starve_aux_we",    RF_WE,      1'b1);
    check("starve_aux_addr",  RF_WADDR,   4'd7);
    check("starve_aux_data",  RF_WDATA,   16'h7777);
    cycle();
    check("starve_wb_resume", RF_WADDR,   4'd2);
    check("starve_wb_we",     RF_WE,      1'b1);

    // Full queue: third offer held until a pop frees a slot
    AUX_VALID = 1'b1; AUX_ADDR = 4'd8; AUX_DATA = 16'hA0A0;
    cycle();
    AUX_ADDR = 4'd9; AUX_DATA = 16'hB0B0;
    cycle();
    check("full_ready_low", AUX_READY, 1'b0);
    AUX_ADDR = 4'd10; AUX_DATA = 16'hC0C0;
    waits = 0;
    while (!AUX_READY && waits < 20) begin
      cycle();
      waits++;
    end
    check("full_wait_bound", waits < 20, 1'b1);
    check("full_pop_addr", RF_WADDR, 4'd8);
    check("full_pop_we",   RF_WE,    1'b1);
    cycle();
    AUX_VALID = 1'b0;
    check("full_third_in", PENDING, 16'h0600);
    WB_ON = 1'b0;
    repeat (4) cycle();

    // Reset mid-operation with two entries queued
    WB_ON = 1'b1; AUX_VALID = 1'b1; AUX_ADDR = 4'd11; AUX_DATA = 16'h0B0B;
    cycle();
    AUX_ADDR = 4'd12; AUX_DATA = 16'h0C0C;
    cycle();
    AUX_VALID = 1'b0; RST = 1'b1;
    cycle();
    check("mid_rst_pending", PENDING,   16'h0000);
    check("mid_rst_ready",   AUX_READY, 1'b1);
    RST = 1'b0; WB_ON = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("mid_rst_no_aux_we", RF_WE, 1'b0);
    end

    // Random traffic; producer holds an un-accepted offer
    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 63) == 0);
      WB_ON = ($urandom_range(0, 3) != 0);
      WB_ADDR = 4'($urandom); WB_DATA = 16'($urandom);
      if (!(AUX_VALID && !m_accept) || RST) begin
        AUX_VALID = $urandom_range(0, 1) == 1;
        AUX_ADDR  = 4'($urandom);
        AUX_DATA  = 16'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
